// File: rtl/text_buffer.sv
// Character-cell text buffer: 16x16 character RAM with a font-ROM read path
// for the overlay stage and a cursor-driven writer that honours CR/LF/BS/FF.
module text_buffer #(
  parameter logic [7:0] BLANK_CHAR     = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [7:0]  char_xy,
  input  logic [3:0]  char_line,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [7:0]  char_pixels,
  input  logic        wr_valid,
  input  logic [7:0]  wr_char,
  output logic        wr_ready,
  output logic [7:0]  cursor_xy,
  output logic        busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0] state;
  logic [7:0] ram [256];
  logic [7:0] clr_addr;
  logic       accept;
  logic       printable;
  logic       we;
  logic [7:0] wa;
  logic [7:0] wd;

  // Handshake outputs are forced low during reset regardless of the state
  // the reset is steering towards.
  assign wr_ready  = (state == IDLE) && !rst;
  assign busy      = (state == CLEAR) && !rst;
  assign accept    = wr_valid && wr_ready;
  assign printable = (wr_char >= 8'h20) && (wr_char <= 8'h7E);

  always_comb begin
    we = 1'b0;
    wa = '0;
    wd = '0;
    if (busy) begin
      we = 1'b1;
      wa = clr_addr;
      wd = BLANK_CHAR;
    end else if (accept) begin
      if (printable) begin
        we = 1'b1;
        wa = cursor_xy;
        wd = wr_char;
      end else if (wr_char == 8'h08 && cursor_xy[3:0] != 4'd0) begin
        we = 1'b1;
        wa = {cursor_xy[7:4], cursor_xy[3:0] - 4'd1};
        wd = BLANK_CHAR;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (we) ram[wa] <= wd;
  end

  // Reading the array in the same edge as the write yields the old contents.
  always_ff @(posedge pclk) begin
    if (rst) font_addr <= '0;
    else     font_addr <= {ram[char_xy][6:0], char_line};
  end

  assign char_pixels = font_data;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= CLEAR_ON_RESET ? CLEAR : IDLE;
      cursor_xy <= '0;
      clr_addr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (wr_char)
              8'h0D: cursor_xy[3:0] <= 4'd0;
              8'h0A: cursor_xy[7:4] <= cursor_xy[7:4] + 4'd1;
              8'h08: if (cursor_xy[3:0] != 4'd0) cursor_xy[3:0] <= cursor_xy[3:0] - 4'd1;
              8'h0C: begin
                state     <= CLEAR;
                cursor_xy <= '0;
                clr_addr  <= '0;
              end
              // 8-bit increment gives column wrap into the next row and FF->00
              default: if (printable) cursor_xy <= cursor_xy + 8'd1;
            endcase
          end
        end
        default: begin
          clr_addr <= clr_addr + 8'd1;
          if (clr_addr == 8'hFF) state <= IDLE;
        end
      endcase
    end
  end

endmodule
